// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU opcode and divide-step constants
package alu_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    // OR with a zero operand leaves the accumulator untouched
    localparam logic [2:0] NOP_OP_DEFAULT = OP_OR;

    localparam logic [3:0] DIV_STATE_FIRST = 4'd1;
    localparam logic [3:0] DIV_STATE_LAST  = 4'd8;

endpackage

// File: rtl/alu_sequencer_ir.sv
// rtl/alu_sequencer_ir.sv - instruction register: register8 operand plus opcode flop
module alu_sequencer_ir (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [10:0] d,
    output logic [10:0] q
);

    logic [2:0] op_q;

    register8 u_operand (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (d[7:0]),
        .q     (q[7:0])
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= 3'd0;
        end else if (load) begin
            op_q <= d[10:8];
        end
    end

    assign q[10:8] = op_q;

endmodule

// File: rtl/register8.sv
// rtl/register8.sv - 8-bit load-enabled register with async active-high reset
module register8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 8'd0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetches instructions from program memory and issues them to the ALU in lockstep
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int         AW     = 8,
    parameter logic [2:0] NOP_OP = NOP_OP_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] pm_addr,
    output logic          pm_re,
    input  logic [10:0]   pm_data,
    output logic [2:0]    opcode,
    output logic [7:0]    in,
    input  logic [3:0]    alu_state,
    input  logic          alu_error,
    output logic          busy,
    output logic          done,
    output logic          seq_err,
    output logic [AW-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_EXEC,
        S_DIVHOLD,
        S_DONE
    } seq_state_t;

    seq_state_t    state;
    logic [AW-1:0] len_r;
    logic [3:0]    hold_cnt;
    logic          exec_phase;
    logic [10:0]   ir;
    logic          last_instr;
    logic          lockstep_fault;

    alu_sequencer_ir u_ir (
        .clk   (clk),
        .reset (reset),
        .load  (state == S_CAPTURE),
        .d     (pm_data),
        .q     (ir)
    );

    // The ALU must report single-cycle in EXEC and the matching divide step in DIVHOLD
    always_comb begin
        lockstep_fault = 1'b0;
        if (state == S_EXEC) begin
            lockstep_fault = alu_error || (alu_state != 4'd0);
        end else if (state == S_DIVHOLD) begin
            lockstep_fault = alu_error || (alu_state != hold_cnt);
        end
    end

    assign last_instr = (pc == len_r - AW'(1));
    assign pm_addr    = pc;
    assign opcode     = exec_phase ? ir[10:8] : NOP_OP;
    assign in         = exec_phase ? ir[7:0]  : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            len_r      <= '0;
            hold_cnt   <= 4'd0;
            exec_phase <= 1'b0;
            seq_err    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            pm_re      <= 1'b0;
        end else begin
            done  <= 1'b0;
            pm_re <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc      <= '0;
                        seq_err <= 1'b0;
                        len_r   <= len;
                        busy    <= 1'b1;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                            pm_re <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state      <= S_EXEC;
                    exec_phase <= 1'b1;
                end
                S_EXEC, S_DIVHOLD: begin
                    if (lockstep_fault) begin
                        seq_err    <= 1'b1;
                        exec_phase <= 1'b0;
                        hold_cnt   <= 4'd0;
                        state      <= S_DONE;
                        done       <= 1'b1;
                    end else if (state == S_EXEC && ir[10:8] == OP_DIV) begin
                        state    <= S_DIVHOLD;
                        hold_cnt <= DIV_STATE_FIRST;
                    end else if (state == S_DIVHOLD && hold_cnt != DIV_STATE_LAST) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end else begin
                        // retire the current instruction
                        exec_phase <= 1'b0;
                        hold_cnt   <= 4'd0;
                        if (last_instr) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            pc    <= pc + AW'(1);
                            state <= S_FETCH;
                            pm_re <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    exec_phase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] len;
    logic [AW-1:0] pm_addr;
    logic          pm_re;
    logic [10:0]   pm_data;
    logic [2:0]    opcode;
    logic [7:0]    in;
    logic [3:0]    alu_state;
    logic          alu_error;
    logic          busy;
    logic          done;
    logic          seq_err;
    logic [AW-1:0] pc;

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.AW(AW), .NOP_OP(3'd3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .pm_addr   (pm_addr),
        .pm_re     (pm_re),
        .pm_data   (pm_data),
        .opcode    (opcode),
        .in        (in),
        .alu_state (alu_state),
        .alu_error (alu_error),
        .busy      (busy),
        .done      (done),
        .seq_err   (seq_err),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    logic [10:0] pmem [0:255];
    always @(posedge clk) begin
        if (pm_re) pm_data <= pmem[pm_addr];
    end

    // Attached ALU: single-cycle ops, DIV walks states 1..8 then writes the quotient
    logic [3:0] alu_st;
    logic [7:0] acc;
    logic [7:0] div_in;
    logic       force_en;
    logic [3:0] force_val;
    assign alu_state = force_en ? force_val : alu_st;
    assign alu_error = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_st <= 4'd0;
            acc    <= 8'd0;
            div_in <= 8'd1;
        end else if (alu_st != 4'd0) begin
            if (alu_st == 4'd8) begin
                alu_st <= 4'd0;
                acc    <= acc / div_in;
            end else begin
                alu_st <= alu_st + 4'd1;
            end
        end else begin
            case (opcode)
                OP_ADD:  acc <= acc + in;
                OP_SUB:  acc <= acc - in;
                OP_AND:  acc <= acc & in;
                OP_OR:   acc <= acc | in;
                OP_LOAD: acc <= in;
                OP_DIV:  begin alu_st <= 4'd1; div_in <= in; end
                OP_XOR:  acc <= acc ^ in;
                default: acc <= ~acc;
            endcase
        end
    end

    logic [10:0] prog [$];
    logic [2:0]  op_trace [0:255];
    int r_done_cyc, r_fetches, r_addr_bad, r_busy_cyc, r_div_run;

    function automatic logic [7:0] ref_apply(input logic [7:0] a, input logic [2:0] op, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return b;
            3'd5: return a / b;
            3'd6: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic int ref_done_cycle();
        int c = 1;
        foreach (prog[i]) c += (prog[i][10:8] == 3'd5) ? 11 : 3;
        return c;
    endfunction

    function automatic logic [7:0] ref_acc();
        logic [7:0] a = 8'd0;
        foreach (prog[i]) a = ref_apply(a, prog[i][10:8], prog[i][7:0]);
        return a;
    endfunction

    // Starts the staged program at a negedge; cycle 1 is the first cycle after start is sampled
    task automatic run_prog(input int pulse_cyc, input int force_cyc);
        int         run = 0;
        logic [7:0] run_in = 8'd0;
        r_done_cyc = -1; r_fetches = 0; r_addr_bad = 0; r_busy_cyc = 0; r_div_run = 0;
        foreach (prog[i]) pmem[i] = prog[i];
        len   = prog.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (cyc < 256) op_trace[cyc] = opcode;
            if (pm_re) begin
                if (pm_addr !== r_fetches[AW-1:0]) r_addr_bad++;
                r_fetches++;
            end
            if (busy) r_busy_cyc++;
            if (opcode == OP_DIV) begin
                if (run > 0 && in == run_in) run++;
                else begin run = 1; run_in = in; end
            end else begin
                run = 0;
            end
            if (run > r_div_run) r_div_run = run;
            if (done) begin
                r_done_cyc = cyc;
                break;
            end
            start     = (cyc == pulse_cyc);
            force_en  = (cyc == force_cyc);
            force_val = 4'd2;
            @(negedge clk);
        end
        start    = 1'b0;
        force_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (pm_re !== 1'b0)   begin bad++; $display("FAIL reset_pm_re got=%0b exp=0", pm_re); end
        total++; if (pm_addr !== 8'd0) begin bad++; $display("FAIL reset_pm_addr got=%0d exp=0", pm_addr); end
        total++; if (pc !== 8'd0)      begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%0b exp=0", seq_err); end
        total++; if (opcode !== 3'd3)  begin bad++; $display("FAIL reset_opcode got=%0d exp=3", opcode); end
        total++; if (in !== 8'd0)      begin bad++; $display("FAIL reset_in got=%0d exp=0", in); end
    endtask

    task automatic test_load_add();
        prog = '{{3'd4, 8'd5}, {3'd0, 8'd3}};
        run_prog(0, 0);
        total++; if (op_trace[3] !== 3'd4) begin bad++; $display("FAIL la_op_c3 got=%0d exp=4", op_trace[3]); end
        total++; if (op_trace[6] !== 3'd0) begin bad++; $display("FAIL la_op_c6 got=%0d exp=0", op_trace[6]); end
        total++; if (r_done_cyc != 7)      begin bad++; $display("FAIL la_done_cyc got=%0d exp=7", r_done_cyc); end
        total++; if (acc !== 8'd8)         begin bad++; $display("FAIL la_acc got=%0d exp=8", acc); end
        total++; if (seq_err !== 1'b0)     begin bad++; $display("FAIL la_seq_err got=%0b exp=0", seq_err); end
        total++; if (r_fetches != 2 || r_addr_bad != 0) begin bad++; $display("FAIL la_fetch got=%0d/%0d exp=2/0", r_fetches, r_addr_bad); end
    endtask

    task automatic test_div();
        prog = '{{3'd4, 8'h40}, {3'd5, 8'h20}};
        run_prog(0, 0);
        total++; if (r_div_run != 9)   begin bad++; $display("FAIL div_hold_run got=%0d exp=9", r_div_run); end
        total++; if (r_done_cyc != 15) begin bad++; $display("FAIL div_done_cyc got=%0d exp=15", r_done_cyc); end
        total++; if (acc !== 8'd2)     begin bad++; $display("FAIL div_acc got=%0d exp=2", acc); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL div_seq_err got=%0b exp=0", seq_err); end
        total++; if (pc !== 8'd1)      begin bad++; $display("FAIL div_pc got=%0d exp=1", pc); end
    endtask

    task automatic test_len_zero();
        prog = {};
        run_prog(0, 0);
        total++; if (r_done_cyc != 1) begin bad++; $display("FAIL len0_done_cyc got=%0d exp=1", r_done_cyc); end
        total++; if (r_fetches != 0)  begin bad++; $display("FAIL len0_pm_re got=%0d exp=0", r_fetches); end
        total++; if (r_busy_cyc != 1) begin bad++; $display("FAIL len0_busy got=%0d exp=1", r_busy_cyc); end
        total++; if (pc !== 8'd0)     begin bad++; $display("FAIL len0_pc got=%0d exp=0", pc); end
    endtask

    task automatic test_back_to_back_start();
        prog = '{{3'd4, 8'd9}, {3'd0, 8'd1}, {3'd3, 8'd6}};
        run_prog(4, 0);
        total++; if (r_done_cyc != 10) begin bad++; $display("FAIL busy_start_done_cyc got=%0d exp=10", r_done_cyc); end
        total++; if (r_fetches != 3 || r_addr_bad != 0) begin bad++; $display("FAIL busy_start_fetch got=%0d/%0d exp=3/0", r_fetches, r_addr_bad); end
        total++; if (pc !== 8'd2)      begin bad++; $display("FAIL busy_start_pc got=%0d exp=2", pc); end
        total++; if (acc !== 8'd14)    begin bad++; $display("FAIL busy_start_acc got=%0d exp=14", acc); end
    endtask

    task automatic test_lockstep_error();
        prog = '{{3'd4, 8'd1}, {3'd0, 8'd2}, {3'd0, 8'd3}, {3'd0, 8'd4}};
        run_prog(0, 6);
        total++; if (r_done_cyc != 7)  begin bad++; $display("FAIL lock_done_cyc got=%0d exp=7", r_done_cyc); end
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL lock_seq_err got=%0b exp=1", seq_err); end
        total++; if (r_fetches != 2)   begin bad++; $display("FAIL lock_fetches got=%0d exp=2", r_fetches); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 6);
            prog = {};
            for (int i = 0; i < n; i++) begin
                logic [2:0] op = (i == 0) ? 3'd4 : 3'($urandom_range(0, 6));
                logic [7:0] v  = (op == 3'd5) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
                prog.push_back({op, v});
            end
            run_prog(0, 0);
            total++; if (r_done_cyc != ref_done_cycle()) begin bad++; $display("FAIL rnd%0d_done_cyc got=%0d exp=%0d", t, r_done_cyc, ref_done_cycle()); end
            total++; if (acc !== ref_acc())               begin bad++; $display("FAIL rnd%0d_acc got=%0d exp=%0d", t, acc, ref_acc()); end
            total++; if (r_fetches != n)                  begin bad++; $display("FAIL rnd%0d_fetches got=%0d exp=%0d", t, r_fetches, n); end
            total++; if (r_addr_bad != 0)                 begin bad++; $display("FAIL rnd%0d_addr got=%0d exp=0", t, r_addr_bad); end
            total++; if (seq_err !== 1'b0)                begin bad++; $display("FAIL rnd%0d_seq_err got=%0b exp=0", t, seq_err); end
            total++; if (pc !== 8'(n - 1))                begin bad++; $display("FAIL rnd%0d_pc got=%0d exp=%0d", t, pc, n - 1); end
        end
    endtask

    task automatic test_reset_mid_div();
        int saw_done = 0;
        int saw_busy = 0;
        prog = '{{3'd4, 8'h40}, {3'd5, 8'h20}};
        foreach (prog[i]) pmem[i] = prog[i];
        len   = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (opcode !== 3'd5) begin bad++; $display("FAIL rst_div_pre_op got=%0d exp=5", opcode); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_div_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_div_done got=%0b exp=0", done); end
        total++; if (pm_re !== 1'b0)   begin bad++; $display("FAIL rst_div_pm_re got=%0b exp=0", pm_re); end
        total++; if (pc !== 8'd0)      begin bad++; $display("FAIL rst_div_pc got=%0d exp=0", pc); end
        total++; if (pm_addr !== 8'd0) begin bad++; $display("FAIL rst_div_pm_addr got=%0d exp=0", pm_addr); end
        total++; if (opcode !== 3'd3)  begin bad++; $display("FAIL rst_div_opcode got=%0d exp=3", opcode); end
        total++; if (in !== 8'd0)      begin bad++; $display("FAIL rst_div_in got=%0d exp=0", in); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) saw_done++;
            if (busy) saw_busy++;
        end
        total++; if (saw_done != 0) begin bad++; $display("FAIL rst_div_no_done got=%0d exp=0", saw_done); end
        total++; if (saw_busy != 0) begin bad++; $display("FAIL rst_div_idle got=%0d exp=0", saw_busy); end
        run_prog(0, 0);
        total++; if (r_done_cyc != 15) begin bad++; $display("FAIL rst_div_rerun_cyc got=%0d exp=15", r_done_cyc); end
        total++; if (acc !== 8'd2)     begin bad++; $display("FAIL rst_div_rerun_acc got=%0d exp=2", acc); end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        force_en  = 1'b0;
        force_val = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_load_add();
        test_div();
        test_len_zero();
        test_back_to_back_start();
        test_lockstep_error();
        test_random();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
